// File: rtl/bram_loader.sv
// bram_loader: framed byte-stream program loader for the instruction BRAM.
// Assembles LE words, writes them, checks the stream sum, optionally reads back.
module bram_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter bit VERIFY     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [7:0]            s_data,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [DATA_WIDTH-1:0] w_dat,
    output logic                  w_enb,
    output logic [3:0]            byte_enb,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic                  r_enb,
    input  logic [DATA_WIDTH-1:0] r_dat,
    output logic                  core_hold,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            err_code,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_CSUM,
        S_VERIFY,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [32:0]         CAP = 33'd1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                  state_q;
    logic [1:0]              bcnt_q;
    logic [23:0]             word_q;
    logic [ADDR_WIDTH:0]     n_q;
    logic [31:0]             sum_q;
    logic [31:0]             csum_q;
    logic [DATA_WIDTH-1:0]   rsum_q;
    logic [ADDR_WIDTH:0]     rcnt_q;
    logic [ADDR_WIDTH:0]     rret_q;
    logic                    rvalid_q;
    logic [ADDR_WIDTH-1:0]   w_addr_q;
    logic [DATA_WIDTH-1:0]   w_dat_q;
    logic                    w_enb_q;
    logic [ADDR_WIDTH-1:0]   r_addr_q;
    logic                    r_enb_q;
    logic                    core_hold_q;
    logic                    done_q;
    logic                    error_q;
    logic [1:0]              err_code_q;
    logic [ADDR_WIDTH:0]     wl_q;

    logic                    byte_fire;
    logic                    last_byte;
    logic [31:0]             word_d;
    logic [31:0]             sum_d;
    logic [DATA_WIDTH-1:0]   rsum_d;
    logic [ADDR_WIDTH:0]     rret_d;
    logic                    oversize;

    // Stream side: ready is a pure function of state, never of s_valid.
    // In DATA it drops once all N words are in, for the final write cycle.
    assign s_ready = (state_q == S_HDR) || (state_q == S_CSUM) ||
                     ((state_q == S_DATA) && (wl_q != n_q));

    assign byte_fire = s_valid && s_ready;
    assign last_byte = (bcnt_q == 2'd3);
    assign word_d    = {s_data, word_q};
    assign sum_d     = sum_q + word_d;
    assign rsum_d    = rsum_q + r_dat;
    assign rret_d    = rret_q + ONE;
    assign oversize  = {1'b0, word_d} > CAP;

    assign w_addr       = w_addr_q;
    assign w_dat        = w_dat_q;
    assign w_enb        = w_enb_q;
    assign byte_enb     = 4'hF;
    assign r_addr       = r_addr_q;
    assign r_enb        = r_enb_q;
    assign core_hold    = core_hold_q;
    assign done         = done_q;
    assign error        = error_q;
    assign err_code     = err_code_q;
    assign words_loaded = wl_q;

    // Load sequencer: byte assembly, BRAM write/read strobes and status.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            bcnt_q      <= 2'd0;
            word_q      <= '0;
            n_q         <= '0;
            sum_q       <= '0;
            csum_q      <= '0;
            rsum_q      <= '0;
            rcnt_q      <= '0;
            rret_q      <= '0;
            rvalid_q    <= 1'b0;
            w_addr_q    <= '0;
            w_dat_q     <= '0;
            w_enb_q     <= 1'b0;
            r_addr_q    <= '0;
            r_enb_q     <= 1'b0;
            core_hold_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_code_q  <= 2'b00;
            wl_q        <= '0;
        end else begin
            w_enb_q  <= 1'b0;
            r_enb_q  <= 1'b0;
            rvalid_q <= r_enb_q;

            if (byte_fire) begin
                bcnt_q <= bcnt_q + 2'd1;
                word_q <= {s_data, word_q[23:8]};
            end

            unique case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state_q     <= S_HDR;
                        core_hold_q <= 1'b1;
                        done_q      <= 1'b0;
                        error_q     <= 1'b0;
                        err_code_q  <= 2'b00;
                        wl_q        <= '0;
                        bcnt_q      <= 2'd0;
                        sum_q       <= '0;
                    end
                end

                S_HDR: begin
                    if (byte_fire && last_byte) begin
                        n_q <= word_d[ADDR_WIDTH:0];
                        if (oversize) begin
                            state_q    <= S_ERR;
                            error_q    <= 1'b1;
                            err_code_q <= 2'b01;
                        end else if (word_d == 32'd0) begin
                            state_q <= S_CSUM;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end
                end

                S_DATA: begin
                    if (wl_q == n_q) begin
                        state_q <= S_CSUM;
                    end else if (byte_fire && last_byte) begin
                        w_enb_q  <= 1'b1;
                        w_addr_q <= wl_q[ADDR_WIDTH-1:0];
                        w_dat_q  <= word_d;
                        sum_q    <= sum_d;
                        wl_q     <= wl_q + ONE;
                    end
                end

                S_CSUM: begin
                    if (byte_fire && last_byte) begin
                        csum_q <= word_d;
                        if (word_d != sum_q) begin
                            state_q    <= S_ERR;
                            error_q    <= 1'b1;
                            err_code_q <= 2'b10;
                        end else if (VERIFY && (n_q != '0)) begin
                            state_q  <= S_VERIFY;
                            r_enb_q  <= 1'b1;
                            r_addr_q <= '0;
                            rcnt_q   <= ONE;
                            rret_q   <= '0;
                            rsum_q   <= '0;
                        end else begin
                            state_q     <= S_DONE;
                            done_q      <= 1'b1;
                            core_hold_q <= 1'b0;
                        end
                    end
                end

                S_VERIFY: begin
                    if (rcnt_q != n_q) begin
                        r_enb_q  <= 1'b1;
                        r_addr_q <= rcnt_q[ADDR_WIDTH-1:0];
                        rcnt_q   <= rcnt_q + ONE;
                    end
                    if (rvalid_q) begin
                        rsum_q <= rsum_d;
                        rret_q <= rret_d;
                        if (rret_d == n_q) begin
                            if (rsum_d != csum_q) begin
                                state_q    <= S_ERR;
                                error_q    <= 1'b1;
                                err_code_q <= 2'b11;
                            end else begin
                                state_q     <= S_DONE;
                                done_q      <= 1'b1;
                                core_hold_q <= 1'b0;
                            end
                        end
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
